// File: rtl/counter_mod.sv
// Modulo up/down counter with prescaled enable, sync load/clear, wrap pulse and sticky overflow.
// Define COUNTER_MOD_SATURATE_EN to hold at the boundary instead of wrapping (same ports either way).
module counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] counter_value_o,
  output logic             terminal_count_o,
  output logic             wrap_o,
  output logic             overflow_o
);

  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("counter_mod: WIDTH out of range");
  end
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("counter_mod: MODULO out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("counter_mod: PRESCALE out of range");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             at_bound;

  always_comb begin
    // With PRESCALE=1 the prescaler sits at 0 == PRE_MAX, so tick follows enable_i.
    tick     = enable_i && (pre_q == PRE_MAX);
    at_bound = up_down_i ? (cnt_q == MAX_VAL) : (cnt_q == '0);

    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;

    if (clear_i) begin
      cnt_d = '0;
      pre_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      cnt_d = (load_value_i > MAX_VAL) ? MAX_VAL : load_value_i;
      pre_d = '0;
    end else begin
      if (enable_i) begin
        pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (tick) begin
        if (at_bound) begin
          ovf_d = 1'b1;
`ifdef COUNTER_MOD_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d  = up_down_i ? '0 : MAX_VAL;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = up_down_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign counter_value_o  = cnt_q;
  assign terminal_count_o = at_bound;
  assign wrap_o           = wrap_q;
  assign overflow_o       = ovf_q;

endmodule
